// File: rtl/tug_key_conditioner.sv
// Tug-of-war key conditioner: per-channel 2-flop sync, debounce FSM and press-edge pulse.
// Optional build macro TUG_KEY_ACTIVE_LOW_EN selects active-low raw key inputs.
module tug_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_raw,
  input  logic key_r_raw,
  output logic L,
  output logic R,
  output logic held_l,
  output logic held_r
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARM    = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;
  localparam logic [1:0] DISARM = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Index 0 is the left channel, index 1 the right channel.
  logic [1:0]            key_s;
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0][1:0]       state_q, state_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0]            held_q, held_d;

`ifdef TUG_KEY_ACTIVE_LOW_EN
  assign key_s = ~{key_r_raw, key_l_raw};
`else
  assign key_s = {key_r_raw, key_l_raw};
`endif

  always_comb begin
    sync1_d = key_s;
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pulse_d[i] = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = ARM;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = IDLE;
          end
        end
        ARM: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = HELD;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync2_q[i]) begin
            state_d[i] = DISARM;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = HELD;
          end
        end
        DISARM: begin
          // Release bounce returns to HELD silently; pulses only come from ARM.
          if (sync2_q[i]) begin
            state_d[i] = HELD;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      held_d[i] = (state_d[i] == HELD) || (state_d[i] == DISARM);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= {IDLE, IDLE};
      cnt_q   <= '0;
      pulse_q <= '0;
      held_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign L      = pulse_q[0];
  assign R      = pulse_q[1];
  assign held_l = held_q[0];
  assign held_r = held_q[1];

endmodule

// File: tb/tb_tug_key_conditioner.sv
// Scoreboard bench for tug_key_conditioner: expected pulses and level samples are queued
// by the stimulus, and a monitor compares them against the DUT at each falling edge.
module tb_tug_key_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic key_l_raw;
  logic key_r_raw;
  logic L, R, held_l, held_r;

`ifdef TUG_KEY_ACTIVE_LOW_EN
  localparam logic ON = 1'b0;
`else
  localparam logic ON = 1'b1;
`endif
  localparam logic OFF = ~ON;

  typedef struct {
    int   cyc;
    logic l;
    logic r;
  } pulse_t;

  typedef struct {
    int   cyc;
    logic l;
    logic r;
    logic hl;
    logic hr;
  } samp_t;

  pulse_t pq[$];
  samp_t  sq[$];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  tug_key_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_l_raw(key_l_raw),
    .key_r_raw(key_r_raw),
    .L(L),
    .R(R),
    .held_l(held_l),
    .held_r(held_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Drive press state (1 = pressed) for n cycles; inputs change just after a falling edge.
  task automatic keys(input bit pl, input bit pr, input int n);
    key_l_raw = pl ? ON : OFF;
    key_r_raw = pr ? ON : OFF;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input int d, input logic l, input logic r);
    pulse_t p;
    p.cyc = cyc + d;
    p.l = l;
    p.r = r;
    pq.push_back(p);
  endtask

  task automatic push_samp(input int d, input logic l, input logic r,
                           input logic hl, input logic hr);
    samp_t s;
    s.cyc = cyc + d;
    s.l = l;
    s.r = r;
    s.hl = hl;
    s.hr = hr;
    sq.push_back(s);
  endtask

  // Monitor: pops a pulse entry whenever L or R is high, and checks due level samples.
  initial begin
    pulse_t p;
    samp_t  s;
    forever begin
      @(negedge clk);
      if (L || R) begin
        total++;
        if (pq.size() == 0) begin
          bad++;
          $display("FAIL pulse_unexpected: cyc=%0d got L=%b R=%b, required no pulse", cyc, L, R);
        end else begin
          p = pq.pop_front();
          if (p.cyc != cyc || p.l !== L || p.r !== R) begin
            bad++;
            $display("FAIL pulse: got L=%b R=%b at cyc %0d, required L=%b R=%b at cyc %0d",
                     L, R, cyc, p.l, p.r, p.cyc);
          end
        end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        total++;
        if (s.cyc != cyc || {L, R, held_l, held_r} !== {s.l, s.r, s.hl, s.hr}) begin
          bad++;
          $display("FAIL sample@%0d: got L,R,held_l,held_r=%b%b%b%b at cyc %0d, required %b%b%b%b",
                   s.cyc, L, R, held_l, held_r, cyc, s.l, s.r, s.hl, s.hr);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    keys(1'b0, 1'b0, 2);
    push_samp(1, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b0, 1'b0, 2);
    reset = 1'b0;
    keys(1'b0, 1'b0, 5);
    push_samp(1, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b0, 1'b0, 2);

    // Clean left press, 20 cycles
    push_pulse(7, 1'b1, 1'b0);
    push_samp(6, 1'b0, 1'b0, 1'b0, 1'b0);
    push_samp(7, 1'b1, 1'b0, 1'b1, 1'b0);
    push_samp(8, 1'b0, 1'b0, 1'b1, 1'b0);
    push_samp(26, 1'b0, 1'b0, 1'b1, 1'b0);
    push_samp(27, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b1, 1'b0, 20);
    keys(1'b0, 1'b0, 15);

    // Right bounce 1 high, 1 low, 2 high: nothing qualifies
    push_samp(5, 1'b0, 1'b0, 1'b0, 1'b0);
    push_samp(8, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b0, 1'b1, 1);
    keys(1'b0, 1'b0, 1);
    keys(1'b0, 1'b1, 2);
    keys(1'b0, 1'b0, 12);

    // Simultaneous press, 10 cycles
    push_pulse(7, 1'b1, 1'b1);
    push_samp(7, 1'b1, 1'b1, 1'b1, 1'b1);
    push_samp(16, 1'b0, 1'b0, 1'b1, 1'b1);
    push_samp(17, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b1, 1'b1, 10);
    keys(1'b0, 1'b0, 15);

    // Left held 15 cycles then release bounce; last low run starts 8 cycles in
    push_pulse(7, 1'b1, 1'b0);
    push_samp(7, 1'b1, 1'b0, 1'b1, 1'b0);
    keys(1'b1, 1'b0, 15);
    push_samp(6, 1'b0, 1'b0, 1'b1, 1'b0);
    push_samp(14, 1'b0, 1'b0, 1'b1, 1'b0);
    push_samp(15, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b0, 1'b0, 2);
    keys(1'b1, 1'b0, 2);
    keys(1'b0, 1'b0, 2);
    keys(1'b1, 1'b0, 2);
    keys(1'b0, 1'b0, 15);

    // Reset pulse while left is in ARM; key must re-qualify afterwards
    push_samp(4, 1'b0, 1'b0, 1'b0, 1'b0);
    push_samp(7, 1'b0, 1'b0, 1'b0, 1'b0);
    push_samp(10, 1'b0, 1'b0, 1'b0, 1'b0);
    push_samp(11, 1'b1, 1'b0, 1'b1, 1'b0);
    push_pulse(11, 1'b1, 1'b0);
    keys(1'b1, 1'b0, 3);
    reset = 1'b1;
    keys(1'b1, 1'b0, 1);
    reset = 1'b0;
    keys(1'b1, 1'b0, 16);
    keys(1'b0, 1'b0, 15);

    // Idle raw level for 20 cycles, then a lone right press
    push_samp(10, 1'b0, 1'b0, 1'b0, 1'b0);
    push_samp(19, 1'b0, 1'b0, 1'b0, 1'b0);
    keys(1'b0, 1'b0, 20);
    push_pulse(7, 1'b0, 1'b1);
    push_samp(7, 1'b0, 1'b1, 1'b0, 1'b1);
    keys(1'b0, 1'b1, 10);
    keys(1'b0, 1'b0, 15);

    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("FAIL pulses_missing: got %0d expected pulses never seen, required 0", pq.size());
    end
    total++;
    if (sq.size() != 0) begin
      bad++;
      $display("FAIL samples_left: got %0d unchecked samples, required 0", sq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
